// File: rtl/gate_truth_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer: FSM state
// encoding, settle counter width and the default gate input count.
package gate_seq_pkg;

    localparam int SETTLE_W     = 4;
    localparam int DEFAULT_N_IN = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/gate_truth_sequencer_settle_timer.sv
// Loadable down-counter that times how long each vector settles.
// The counter stops at zero. 'expired' flags the cycle in which the count
// reaches zero on the coming edge, so the FSM can leave SETTLE exactly
// SETTLE cycles after the load.
module settle_timer
    import gate_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SETTLE_W-1:0] value,
    output logic                expired
);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    // Next count: a load wins; otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q <= SETTLE_W'(1));

endmodule

// File: rtl/gate_truth_sequencer.sv
// Truth-table sweep controller for a small combinational gate. It drives
// every input vector in turn and holds each one for SETTLE+1 cycles. On the
// last edge of that window it samples the gate output. When the sweep ends,
// it compares the captured table against the expected table latched at start.
module gate_truth_sequencer
    import gate_seq_pkg::*;
#(
    parameter  int N_IN   = DEFAULT_N_IN,
    parameter  int SETTLE = 1,
    localparam int ROWS   = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [ROWS-1:0] expected,
    output logic [N_IN-1:0] drv,
    input  logic            gate_s,
    output logic            busy,
    output logic            done,
    output logic [ROWS-1:0] table_out,
    output logic            pass,
    output logic [ROWS-1:0] mismatch_mask
);

    localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);

    seq_state_e      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] drv_q, drv_d;
    logic [ROWS-1:0] exp_q, exp_d;
    logic [ROWS-1:0] table_q, table_d;
    logic [ROWS-1:0] mask_q, mask_d;
    logic            pass_q, pass_d;
    logic            timer_load;
    logic            timer_expired;

    settle_timer u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (SETTLE_VAL),
        .expired (timer_expired)
    );

    // Next-state and datapath updates. With SETTLE=0 the SETTLE state is
    // skipped entirely, so one vector is handled per cycle in SAMPLE.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drv_d      = drv_q;
        exp_d      = exp_q;
        table_d    = table_q;
        mask_d     = mask_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d      = expected;
                    table_d    = '0;
                    mask_d     = '0;
                    pass_d     = 1'b0;
                    idx_d      = '0;
                    drv_d      = '0;
                    timer_load = 1'b1;
                    if (SETTLE == 0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    drv_d   = '0;
                    pass_d  = 1'b0;
                    mask_d  = '0;
                end else if (timer_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    drv_d   = '0;
                    pass_d  = 1'b0;
                    mask_d  = '0;
                end else begin
                    table_d[idx_q] = gate_s;
                    if (&idx_q) begin
                        // Last row: grade the completed table on the way to DONE.
                        state_d = ST_DONE;
                        drv_d   = '0;
                        pass_d  = (table_d == exp_q);
                        mask_d  = table_d ^ exp_q;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        drv_d      = idx_q + 1'b1;
                        timer_load = 1'b1;
                        if (SETTLE == 0) begin
                            state_d = ST_SAMPLE;
                        end else begin
                            state_d = ST_SETTLE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drv_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drv_q   <= drv_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    assign drv           = drv_q;
    assign busy          = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done          = (state_q == ST_DONE);
    assign table_out     = table_q;
    assign pass          = pass_q;
    assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer. Two instances are used: SETTLE=1 (s1) and
// SETTLE=0 (s0). Each drives a behavioural gate that is selected per sweep.
// Each start pushes the hand-computed result into a scoreboard queue. A monitor
// pops one entry on every done pulse and compares it.
module tb_gate_truth_sequencer;

    typedef struct {
        logic [3:0] tbl;
        logic       pas;
        logic [3:0] mask;
        int         done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, abort1, gs1, busy1, done1, pass1;
    logic [3:0] exp1, tbl1, mask1;
    logic [1:0] drv1;
    logic       start0, abort0, gs0, busy0, done0, pass0;
    logic [3:0] exp0, tbl0, mask0;
    logic [1:0] drv0;
    int         gsel1, gsel0;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         c0;
    exp_t       sb1[$];
    exp_t       sb0[$];
    exp_t       e1, e0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: XNOR, 1: AND, other: OR. v[1] is input a, v[0] is input b.
    function automatic logic gate_fn(input int sel, input logic [1:0] v);
        case (sel)
            0:       return ~(v[1] ^ v[0]);
            1:       return v[1] & v[0];
            default: return v[1] | v[0];
        endcase
    endfunction

    assign gs1 = gate_fn(gsel1, drv1);
    assign gs0 = gate_fn(gsel0, drv0);

    gate_truth_sequencer #(.N_IN(2), .SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .expected(exp1), .drv(drv1), .gate_s(gs1), .busy(busy1),
        .done(done1), .table_out(tbl1), .pass(pass1), .mismatch_mask(mask1)
    );

    gate_truth_sequencer #(.N_IN(2), .SETTLE(0)) u_s0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .expected(exp0), .drv(drv0), .gate_s(gs0), .busy(busy0),
        .done(done0), .table_out(tbl0), .pass(pass0), .mismatch_mask(mask0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitors: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && done1 === 1'b1) begin
            if (sb1.size() == 0) begin
                chk("s1_unexpected_done", {31'd0, done1}, 32'd0);
            end else begin
                e1 = sb1.pop_front();
                chk("s1_table", {28'd0, tbl1}, {28'd0, e1.tbl});
                chk("s1_pass", {31'd0, pass1}, {31'd0, e1.pas});
                chk("s1_mask", {28'd0, mask1}, {28'd0, e1.mask});
                chk("s1_done_cycle", cyc, e1.done_cyc);
                $display("txn s1 done table=%b pass=%b mask=%b cyc=%0d", tbl1, pass1, mask1, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && done0 === 1'b1) begin
            if (sb0.size() == 0) begin
                chk("s0_unexpected_done", {31'd0, done0}, 32'd0);
            end else begin
                e0 = sb0.pop_front();
                chk("s0_table", {28'd0, tbl0}, {28'd0, e0.tbl});
                chk("s0_pass", {31'd0, pass0}, {31'd0, e0.pas});
                chk("s0_mask", {28'd0, mask0}, {28'd0, e0.mask});
                chk("s0_done_cycle", cyc, e0.done_cyc);
                $display("txn s0 done table=%b pass=%b mask=%b cyc=%0d", tbl0, pass0, mask0, cyc);
            end
        end
    end

    // Pulse start for one edge and return at the negedge after acceptance
    // (c0 = cycle count there). Optionally queue the expected sweep result.
    task automatic sweep_start(input int inst, input logic [3:0] expv, input int gsel,
                               input bit push, input logic [3:0] etbl, input logic epass,
                               input logic [3:0] emask, input bit with_abort,
                               output int c0_o);
        exp_t e;
        @(negedge clk);
        if (inst == 1) begin
            exp1 = expv; gsel1 = gsel; start1 = 1'b1; abort1 = with_abort;
        end else begin
            exp0 = expv; gsel0 = gsel; start0 = 1'b1; abort0 = with_abort;
        end
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; abort1 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        c0_o = cyc;
        if (push) begin
            e.tbl      = etbl;
            e.pas      = epass;
            e.mask     = emask;
            e.done_cyc = c0_o + ((inst == 1) ? 8 : 4);
            if (inst == 1) sb1.push_back(e);
            else           sb0.push_back(e);
        end
        $display("txn start inst=%0d expected=%b gate=%0d cyc=%0d", inst, expv, gsel, c0_o);
    endtask

    task automatic wait_done(input int inst);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (inst == 1) ? done1 : done0;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_done inst=%0d actual=no_done required=done", inst);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; exp1 = 4'd0; gsel1 = 0;
        start0 = 1'b0; abort0 = 1'b0; exp0 = 4'd0; gsel0 = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        chk("rst_drv", {30'd0, drv1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_table", {28'd0, tbl1}, 32'd0);
        chk("rst_pass", {31'd0, pass1}, 32'd0);
        chk("rst_mask", {28'd0, mask1}, 32'd0);
        chk("rst_s0_busy", {31'd0, busy0}, 32'd0);

        // XNOR, expected 1001, SETTLE=1: drv steps every 2 cycles, done at +8.
        sweep_start(1, 4'b1001, 0, 1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, c0);
        for (int j = 0; j < 8; j++) begin
            chk("s1_step_drv", {30'd0, drv1}, j / 2);
            chk("s1_step_busy", {31'd0, busy1}, 32'd1);
            @(negedge clk);
        end
        chk("s1_done_pulse", {31'd0, done1}, 32'd1);
        chk("s1_done_drv", {30'd0, drv1}, 32'd0);
        chk("s1_done_busy", {31'd0, busy1}, 32'd0);

        // XNOR gate against an AND expectation: row 0 mismatches.
        sweep_start(1, 4'b1000, 0, 1'b1, 4'b1001, 1'b0, 4'b0001, 1'b0, c0);
        wait_done(1);

        // Real AND gate against AND expectation.
        sweep_start(1, 4'b1000, 1, 1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0, c0);
        wait_done(1);

        // SETTLE=0: one vector per cycle, done at +4; abort with start is ignored.
        sweep_start(0, 4'b1001, 0, 1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1, c0);
        for (int j = 0; j < 4; j++) begin
            chk("s0_step_drv", {30'd0, drv0}, j);
            chk("s0_step_busy", {31'd0, busy0}, 32'd1);
            @(negedge clk);
        end
        chk("s0_done_pulse", {31'd0, done0}, 32'd1);

        // SETTLE=0, OR gate against 0110: row 3 mismatches.
        sweep_start(0, 4'b0110, 2, 1'b1, 4'b1110, 1'b0, 4'b1000, 1'b0, c0);
        wait_done(0);

        // Start re-pulsed at cycles 2 and 8; expected input changed mid-sweep.
        sweep_start(1, 4'b1001, 0, 1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, c0);
        @(negedge clk);
        @(negedge clk);
        start1 = 1'b1;
        exp1   = 4'b0000;
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        chk("restart_done_c8", {31'd0, done1}, 32'd1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("restart_busy_c9", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        chk("restart_busy_c10", {31'd0, busy1}, 32'd0);
        chk("restart_done_c10", {31'd0, done1}, 32'd0);

        // Next start after returning to IDLE is accepted (OR gate, pass).
        sweep_start(1, 4'b1110, 2, 1'b1, 4'b1110, 1'b1, 4'b0000, 1'b0, c0);
        chk("accept_busy", {31'd0, busy1}, 32'd1);
        wait_done(1);

        // Abort while drv=10: rows 0,1 kept, no done.
        sweep_start(1, 4'b1001, 0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, c0);
        repeat (4) @(negedge clk);
        chk("abort_pre_drv", {30'd0, drv1}, 32'd2);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_drv", {30'd0, drv1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_table", {28'd0, tbl1}, 32'b0001);
        chk("abort_pass", {31'd0, pass1}, 32'd0);
        chk("abort_mask", {28'd0, mask1}, 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_idle_busy", {31'd0, busy1}, 32'd0);

        // Asynchronous reset mid-cycle during SETTLE.
        sweep_start(1, 4'b1001, 0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, c0);
        @(negedge clk);
        @(negedge clk);
        chk("prereset_drv", {30'd0, drv1}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_drv", {30'd0, drv1}, 32'd0);
        chk("async_rst_busy", {31'd0, busy1}, 32'd0);
        chk("async_rst_done", {31'd0, done1}, 32'd0);
        chk("async_rst_table", {28'd0, tbl1}, 32'd0);
        chk("async_rst_pass", {31'd0, pass1}, 32'd0);
        chk("async_rst_mask", {28'd0, mask1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sweep_start(1, 4'b1000, 1, 1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0, c0);
        wait_done(1);

        repeat (3) @(negedge clk);
        chk("sb1_drained", sb1.size(), 32'd0);
        chk("sb0_drained", sb0.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
